// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle-high level.
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] ff_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_reg <= 2'b11;
    end else begin
      ff_reg <= {ff_reg[0], d};
    end
  end

  assign q = ff_reg[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 7/8 data bits, optional even/odd parity, one stop bit,
// break-aware so a held-low line does not retrigger.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       rx_in,
  input  logic       d_num,
  input  logic [1:0] par,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             d_num_reg;
  logic [1:0]       par_reg;
  logic             par_bad_reg;
  logic             rx_s;

  logic mid_start;
  logic bit_tick;
  logic last_bit;
  logic parity_on;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_in),
    .q       (rx_s)
  );

  // START counts to mid-bit once; afterwards each full period lands on mid-bit again.
  assign mid_start = (cnt_reg == MID_CNT);
  assign bit_tick  = (cnt_reg == FULL_CNT);
  assign last_bit  = (bit_idx_reg == {2'b11, d_num_reg});
  assign parity_on = (par_reg != PAR_NONE) && (par_reg != 2'b11);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (enable && !rx_s) state_next = START;
      end
      START: begin
        if (mid_start) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick && last_bit) state_next = parity_on ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) state_next = rx_s ? IDLE : BREAK_WAIT;
      end
      BREAK_WAIT: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      d_num_reg   <= 1'b0;
      par_reg     <= PAR_NONE;
      par_bad_reg <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (enable && !rx_s) begin
            d_num_reg   <= d_num;
            par_reg     <= par;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            par_bad_reg <= 1'b0;
          end
        end
        START: begin
          cnt_reg <= mid_start ? '0 : cnt_reg + CNT_W'(1);
        end
        DATA: begin
          cnt_reg <= bit_tick ? '0 : cnt_reg + CNT_W'(1);
          if (bit_tick) begin
            shift_reg[bit_idx_reg] <= rx_s;
            if (!last_bit) bit_idx_reg <= bit_idx_reg + 3'd1;
          end
        end
        PARITY: begin
          cnt_reg <= bit_tick ? '0 : cnt_reg + CNT_W'(1);
          if (bit_tick) par_bad_reg <= (rx_s != parity_bit(shift_reg, par_reg));
        end
        STOP: begin
          cnt_reg <= bit_tick ? '0 : cnt_reg + CNT_W'(1);
          if (bit_tick) begin
            data_out   <= {d_num_reg & shift_reg[7], shift_reg[6:0]};
            data_valid <= 1'b1;
            parity_err <= par_bad_reg;
            frame_err  <= !rx_s;
          end
        end
        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that pairs with the team's UART transmitter. It samples an idle-high serial line and detects the start bit. It then recovers 7 or 8 data bits LSB-first, checks an optional parity bit and validates the stop bit. Each received character is presented as a parallel byte with a one-cycle valid strobe and per-character error flags.

## Interface
Parameters:
- OVERSAMPLE, 16: clock cycles per bit period; must be an even number ≥ 4
- CNT_W, 5: width of the oversample counter; must satisfy 2^CNT_W ≥ OVERSAMPLE

Ports:
- clk  in  1  receive clock; runs at OVERSAMPLE × bit rate; one cycle = one sample tick
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  arms the receiver; sampled only in IDLE
- rx_in  in  1  serial line; asynchronous to clk; idle high
- d_num  in  1  1 = 8 data bits, 0 = 7 data bits; latched at start detect
- par  in  2  00 none, 01 even (parity bit = XOR of data), 10 odd (= ~XOR), 11 treated as none; latched at start detect
- data_out  out  8  last received character; bit 7 forced to 0 in 7-bit mode
- data_valid  out  1  one-cycle pulse per completed frame
- parity_err  out  1  parity mismatch on the last frame; valid with data_valid and held until the next data_valid
- frame_err  out  1  stop bit sampled low on the last frame; valid with data_valid and held until the next data_valid
- busy  out  1  high in every state except IDLE

## Operation
- rx_in passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
- The FSM has six states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: when enable=1 and rx_s=0, latch d_num/par, clear the counter and go to START.
- START: at count OVERSAMPLE/2-1 (mid-bit), rx_s=0 means restart the counter and go to DATA. rx_s=1 is a false start: return to IDLE with no strobe.
- DATA: sample rx_s every OVERSAMPLE cycles at mid-bit into shift position bit_idx, LSB first. After bit 6 (d_num=0) or bit 7 (d_num=1), go to PARITY if par is 01 or 10, otherwise go to STOP.
- PARITY: sample once at mid-bit and compare with the expected bit computed over the received data bits only.
- STOP: sample at mid-bit. Update data_out, parity_err and frame_err in that cycle and pulse data_valid.
  - rx_s=1: go to IDLE.
  - rx_s=0: set frame_err and go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s=1, then go to IDLE. This blocks re-triggering on a held-low line.
- enable falling mid-frame has no effect; the current frame completes.
- The expected parity bit is 0 for even parity with an even count of ones.

## Timing
- Reset values: data_out=8'h00, data_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, counters=0.
- An assertion of reset_n mid-frame aborts immediately with no strobe. The first frame after release requires a fresh falling edge.
- Start detect occurs 2 cycles (synchronizer delay) after the falling edge on rx_in.
- data_valid rises (1 + N_data + N_par) × OVERSAMPLE + OVERSAMPLE/2 cycles after start detect.
  - 8N1 at OVERSAMPLE=16: 152 cycles.
  - 8E1: 168 cycles.
- data_valid lasts exactly 1 cycle. data_out holds until the next strobe.
- Back-to-back frames are accepted: the next start bit may begin at the end of the stop bit. The receiver is back in IDLE OVERSAMPLE/2 cycles before the stop-bit boundary.
- Bit counter is 3 bits and does not wrap past 7. The oversample counter is CNT_W bits and resets at every bit boundary.

## Structure
- Shared package uart_pkg, which also serves the transmitter:
  - rx_state_t enum
  - parity encoding constants PAR_NONE, PAR_EVEN, PAR_ODD
  - default OVERSAMPLE
- Sub-module uart_sync2: a 2-flop synchronizer with reset value 1.
- Everything else stays in uart_rx, about 200 lines.

## Test plan
- 8N1, enable=1, send 0xA5 → data_out=0xA5, data_valid 152 cycles after start detect, both error flags 0.
- 8 bits even parity, send 0xA5 with parity bit 0 → no error. Repeat with parity bit 1 → parity_err=1 and data_out still 0xA5.
- 7 bits odd parity, send 0x35 (four ones) with parity bit 1 → data_out=0x35, bit 7=0, no error.
- 8 cycles of low glitch on rx_in, then high → no data_valid, FSM back in IDLE.
- 8N1, send 0x00 with stop bit low, hold line low 100 cycles → frame_err=1 with strobe, busy=1 until line high, then a following 0x3C is received correctly.
- Assert reset_n low at bit 4 of a frame → all outputs at reset values. enable=0 with a frame sent → no strobe.
